// File: rtl/regfile_32.sv
// 32 x 32-bit MIPS register file: two async read ports (S, T), one sync write port (D).
// Optional write-through bypass on the read ports when REGFILE_BYPASS_EN is defined.
module regfile_32 #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 5,
  parameter int                SP_IDX   = 29,
  parameter logic [DATA_W-1:0] SP_RESET = 32'h0000_03FC
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              D_En,
  input  logic [ADDR_W-1:0] D_Addr,
  input  logic [DATA_W-1:0] D,
  input  logic [ADDR_W-1:0] S_Addr,
  input  logic [ADDR_W-1:0] T_Addr,
  output logic [DATA_W-1:0] S,
  output logic [DATA_W-1:0] T
);
  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] rf [NREG];
  logic              wr_en;

  assign wr_en = D_En && (D_Addr != '0);

  // Entry 0 is only ever loaded by reset, so it stays zero and folds to a constant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++)
        rf[i] <= (i == SP_IDX) ? SP_RESET : '0;
    end else if (wr_en) begin
      rf[D_Addr] <= D;
    end
  end

  always_comb begin
    S = (S_Addr == '0) ? '0 : rf[S_Addr];
    T = (T_Addr == '0) ? '0 : rf[T_Addr];
`ifdef REGFILE_BYPASS_EN
    // Forward the pending writeback so a same-cycle reader sees the new value.
    if (reset_n && wr_en) begin
      if (S_Addr == D_Addr) S = D;
      if (T_Addr == D_Addr) T = D;
    end
`endif
  end
endmodule
